// File: rtl/inst_fetch.sv
// Instruction fetch queue: issues in-order word reads to instruction memory and
// hands returned words, tagged with their fetch PC, to decode in program order.
module inst_fetch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] fill_q, fill_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] nfill_q, nfill_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] outstanding;
    logic          not_full;
    logic          req_ok;
    logic          issue;
    logic          resp_discard;
    logic          resp_accept;
    logic          pop;

    // nfill counts entries holding data, so allocated-but-unfilled needs no
    // pointer full/empty disambiguation.
    assign outstanding  = count_q - nfill_q;
    assign not_full     = count_q < FullCount;
    assign req_ok       = pc_valid && !flush && !reset && not_full;
    assign issue        = req_ok && imem_req_ready;
    assign resp_discard = imem_resp_valid && (drop_q != '0);
    // A response with nothing outstanding and nothing to drop is ignored.
    assign resp_accept  = imem_resp_valid && (drop_q == '0) && (outstanding != '0);
    assign pop          = inst_valid && inst_ready && !flush;

    assign imem_req_valid = req_ok;
    assign imem_req_addr  = {pc_in[31:2], 2'b00};
    assign pc_ready       = issue;
    assign inst_valid     = !reset && (nfill_q != '0);
    assign inst_data      = data_mem_q[head_q];
    assign inst_pc        = pc_mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        fill_d  = fill_q;
        tail_d  = tail_q;
        count_d = count_q;
        nfill_d = nfill_q;
        drop_d  = drop_q;
        if (flush) begin
            head_d  = tail_q;
            fill_d  = tail_q;
            count_d = '0;
            nfill_d = '0;
            // Every request still owed by memory becomes a response to throw away,
            // minus the one arriving right now.
            drop_d  = drop_q + outstanding - CW'(resp_discard) - CW'(resp_accept);
        end else begin
            if (issue) begin
                tail_d = tail_q + AW'(1);
            end
            if (resp_accept) begin
                fill_d = fill_q + AW'(1);
            end
            if (resp_discard) begin
                drop_d = drop_q - CW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(issue) - CW'(pop);
            nfill_d = nfill_q + CW'(resp_accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            nfill_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            nfill_q <= nfill_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_mem_q[tail_q] <= pc_in;
        end
        if (resp_accept && !reset) begin
            data_mem_q[fill_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a
// queue-based reference model with an in-order memory.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        filled;
    } ent_t;

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_valid        (pc_valid),
        .pc_ready        (pc_ready),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        reset           = 1'b0;
        pc_in           = 32'h0;
        pc_valid        = 1'b0;
        flush           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_valid = 1'b1; pc_in = 32'h40; imem_req_ready = 1'b1;
        inst_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h1;
        repeat (2) tick();
        settle();
        checks++; if (pc_ready !== 1'b0) begin errors++;
            $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++;
            $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        tick();
        idle();
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL post_reset_inst_valid: got %b want 0", inst_valid); end
        pc_valid = 1'b1; pc_in = 32'h40; imem_req_ready = 1'b0;
        settle();
        checks++; if (imem_req_valid !== 1'b1 || pc_ready !== 1'b0) begin errors++;
            $display("FAIL stall_handshake: got valid=%b ready=%b want 1 0",
                     imem_req_valid, pc_ready); end
        idle();
    endtask

    task automatic test_single();
        pc_valid = 1'b1; pc_in = 32'h100;
        settle();
        checks++; if (imem_req_valid !== 1'b1 || pc_ready !== 1'b1 ||
                      imem_req_addr !== 32'h100) begin errors++;
            $display("FAIL single_req: got v=%b r=%b a=%h want 1 1 00000100",
                     imem_req_valid, pc_ready, imem_req_addr); end
        tick();
        pc_valid = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL single_latency: got inst_valid=%b want 0", inst_valid); end
        tick();
        imem_resp_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 ||
                      inst_data !== 32'hDEADBEEF) begin errors++;
            $display("FAIL single_inst: got v=%b pc=%h d=%h want 1 00000100 deadbeef",
                     inst_valid, inst_pc, inst_data); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL single_drain: got inst_valid=%b want 0", inst_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 6; i++) begin
            pc_valid = 1'b1; pc_in = 32'(i * 4);
            settle();
            checks++; if (pc_ready !== (i < 4)) begin errors++;
                $display("FAIL full_issue[%0d]: got pc_ready=%b want %b", i, pc_ready, i < 4); end
            tick();
        end
        pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_resp_valid = 1'b1; imem_resp_data = 32'h1000 + 32'(i);
            tick();
        end
        imem_resp_valid = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(i * 4) ||
                          inst_data !== 32'h1000 + 32'(i)) begin errors++;
                $display("FAIL full_pop[%0d]: got v=%b pc=%h d=%h want 1 %h %h", i,
                         inst_valid, inst_pc, inst_data, 32'(i * 4), 32'h1000 + 32'(i)); end
            tick();
        end
        inst_ready = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL full_empty: got inst_valid=%b want 0", inst_valid); end
    endtask

    task automatic test_flush_inflight();
        pc_valid = 1'b1; pc_in = 32'h2F0;
        tick();
        pc_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hF0F0;
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_valid = 1'b1; pc_in = 32'h300 + 32'(i * 4);
            tick();
        end
        pc_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2F0) begin errors++;
            $display("FAIL flush_pre: got v=%b pc=%h want 1 000002f0", inst_valid, inst_pc); end
        flush = 1'b1; pc_valid = 1'b1; pc_in = 32'h999;
        settle();
        checks++; if (imem_req_valid !== 1'b0 || pc_ready !== 1'b0) begin errors++;
            $display("FAIL flush_block: got v=%b r=%b want 0 0", imem_req_valid, pc_ready); end
        tick();
        flush = 1'b0; pc_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL flush_clear: got inst_valid=%b want 0", inst_valid); end
        pc_valid = 1'b1; pc_in = 32'h200;
        settle();
        checks++; if (pc_ready !== 1'b1) begin errors++;
            $display("FAIL flush_reissue: got pc_ready=%b want 1", pc_ready); end
        tick();
        pc_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0 + 32'(j);
            tick();
            imem_resp_valid = 1'b0;
            settle();
            checks++; if (inst_valid !== 1'b0) begin errors++;
                $display("FAIL flush_drop[%0d]: got inst_valid=%b want 0", j, inst_valid); end
        end
        imem_resp_valid = 1'b1; imem_resp_data = 32'hC0DE0200;
        tick();
        imem_resp_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 ||
                      inst_data !== 32'hC0DE0200) begin errors++;
            $display("FAIL flush_new: got v=%b pc=%h d=%h want 1 00000200 c0de0200",
                     inst_valid, inst_pc, inst_data); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_pc [4];
        for (int i = 0; i < 4; i++) begin
            pc_valid = 1'b1; pc_in = 32'h400 + 32'(i * 4);
            tick();
        end
        pc_valid = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hD1;
        tick();
        pc_valid = 1'b1; pc_in = 32'h410; inst_ready = 1'b1;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hD2;
        settle();
        checks++; if (pc_ready !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h400 ||
                      inst_data !== 32'hD1) begin errors++;
            $display("FAIL simul_cycle: got r=%b v=%b pc=%h d=%h want 0 1 00000400 000000d1",
                     pc_ready, inst_valid, inst_pc, inst_data); end
        tick();
        inst_ready = 1'b0; imem_resp_valid = 1'b0;
        settle();
        checks++; if (pc_ready !== 1'b1 || inst_pc !== 32'h404 || inst_data !== 32'hD2)
            begin errors++;
            $display("FAIL simul_resume: got r=%b pc=%h d=%h want 1 00000404 000000d2",
                     pc_ready, inst_pc, inst_data); end
        tick();
        pc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_resp_valid = 1'b1; imem_resp_data = 32'hD3 + 32'(i);
            tick();
        end
        imem_resp_valid = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc[i] = 32'h404 + 32'(i * 4);
            settle();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] ||
                          inst_data !== 32'hD2 + 32'(i)) begin errors++;
                $display("FAIL simul_pop[%0d]: got v=%b pc=%h d=%h want 1 %h %h", i,
                         inst_valid, inst_pc, inst_data, exp_pc[i], 32'hD2 + 32'(i)); end
            tick();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            pc_valid = 1'b1; pc_in = 32'h500 + 32'(i * 4);
            tick();
        end
        pc_valid = 1'b0;
        reset = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD;
        settle();
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_cycle: got v=%b rv=%b want 0 0", inst_valid, imem_req_valid); end
        tick();
        reset = 1'b0; imem_resp_data = 32'hBAD1;
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_after: got inst_valid=%b want 0", inst_valid); end
        tick();
        imem_resp_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_stale: got inst_valid=%b want 0", inst_valid); end
        pc_valid = 1'b1; pc_in = 32'h0;
        tick();
        pc_valid = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h11110000;
        tick();
        imem_resp_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h11110000)
            begin errors++;
            $display("FAIL midreset_fetch: got v=%b pc=%h d=%h want 1 00000000 11110000",
                     inst_valid, inst_pc, inst_data); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        pc_valid = 1'b1; pc_in = 32'h103;
        settle();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++;
            $display("FAIL misalign_addr: got v=%b a=%h want 1 00000100",
                     imem_req_valid, imem_req_addr); end
        tick();
        pc_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hABCD;
        tick();
        imem_resp_valid = 1'b0;
        settle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h103 || inst_data !== 32'hABCD)
            begin errors++;
            $display("FAIL misalign_inst: got v=%b pc=%h d=%h want 1 00000103 0000abcd",
                     inst_valid, inst_pc, inst_data); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    // Model: decode sees fetches in program order; memory answers requests in
    // order; a flush turns every answer still owed into one to be thrown away.
    task automatic test_random();
        ent_t        mq[$];
        ent_t        e;
        logic [31:0] mem_q[$];
        int          mdrop;
        int          n;
        int          outst;
        bit          e_req;
        bit          e_rdy;
        bit          e_iv;
        mdrop = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pc_valid        = ($urandom_range(0, 3) != 0);
            pc_in           = $urandom;
            inst_ready      = ($urandom_range(0, 1) == 1);
            flush           = ($urandom_range(0, 24) == 0);
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                imem_resp_valid = 1'b1;
                mem_q.delete(0);
            end
            // Memory holds at most DEPTH requests in flight.
            imem_req_ready = (mem_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            settle();
            n     = mq.size();
            e_req = pc_valid && !flush && (n < DEPTH);
            e_rdy = e_req && imem_req_ready;
            e_iv  = (n > 0) && mq[0].filled;
            checks++; if (imem_req_valid !== e_req || pc_ready !== e_rdy) begin errors++;
                $display("FAIL rand_req cyc %0d: got v=%b r=%b want %b %b", cyc,
                         imem_req_valid, pc_ready, e_req, e_rdy); end
            if (e_req) begin
                checks++; if (imem_req_addr !== {pc_in[31:2], 2'b00}) begin errors++;
                    $display("FAIL rand_addr cyc %0d: got %h want %h", cyc, imem_req_addr,
                             {pc_in[31:2], 2'b00}); end
            end
            checks++; if (inst_valid !== e_iv) begin errors++;
                $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, inst_valid, e_iv); end
            if (e_iv) begin
                checks++; if (inst_pc !== mq[0].pc || inst_data !== mq[0].data) begin errors++;
                    $display("FAIL rand_inst cyc %0d: got pc=%h d=%h want %h %h", cyc,
                             inst_pc, inst_data, mq[0].pc, mq[0].data); end
            end
            tick();
            outst = 0;
            foreach (mq[k]) if (!mq[k].filled) outst++;
            if (e_rdy) mem_q.push_back({pc_in[31:2], 2'b00});
            if (flush) begin
                if (imem_resp_valid && mdrop > 0) mdrop = mdrop - 1 + outst;
                else if (imem_resp_valid && outst > 0) mdrop = outst - 1;
                else mdrop = mdrop + outst;
                mq.delete();
            end else begin
                if (imem_resp_valid) begin
                    if (mdrop > 0) begin
                        mdrop--;
                    end else begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (!mq[k].filled) begin
                                e = mq[k];
                                e.filled = 1'b1;
                                e.data = imem_resp_data;
                                mq[k] = e;
                                break;
                            end
                        end
                    end
                end
                if (e_iv && inst_ready) mq.delete(0);
                if (e_rdy) begin
                    e.pc = pc_in; e.data = 32'h0; e.filled = 1'b0;
                    mq.push_back(e);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_single();
        test_full();
        test_flush_inflight();
        test_simultaneous();
        test_reset_mid();
        test_misaligned();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pc_in  input  32  fetch address from the PC stage.
REQ-005 SHALL have port pc_valid  input  1  pc_in is valid.
REQ-006 SHALL have port pc_ready  output  1  pc_in is accepted this cycle; the PC stage advances only on pc_valid && pc_ready.
REQ-007 SHALL have port flush  input  1  discard all queued and in-flight fetches.
REQ-008 SHALL have port imem_req_valid  output  1  memory read request.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-010 SHALL have port imem_req_addr  output  32  request word address.
REQ-011 SHALL have port imem_resp_valid  input  1  read data returned (in order, no backpressure).
REQ-012 SHALL have port imem_resp_data  input  32  read data.
REQ-013 SHALL have port inst_valid  output  1  instruction available to decode.
REQ-014 SHALL have port inst_ready  input  1  decode consumes the instruction.
REQ-015 SHALL have port inst_data  output  32  instruction word.
REQ-016 SHALL have port inst_pc  output  32  address of inst_data.

Function
REQ-017 SHALL hold a circular queue of DEPTH entries {pc, data} with pointers head (oldest), fill (next to receive data) and tail (next free), plus count (allocated entries) and drop (responses still to be discarded).
REQ-018 SHALL drive issue = pc_valid && imem_req_ready && !flush && count < DEPTH.
REQ-019 SHALL drive combinationally imem_req_valid = pc_valid && !flush && count < DEPTH, imem_req_addr = {pc_in[31:2], 2'b00}, and pc_ready = issue.
REQ-020 On issue SHALL write pc_in to entry[tail], advance tail (mod DEPTH) and increment count; no same-cycle credit from a pop, so a full queue never issues.
REQ-021 On imem_resp_valid with drop == 0 SHALL write imem_resp_data to entry[fill] and advance fill.
REQ-022 On imem_resp_valid with drop > 0 SHALL discard the data and decrement drop.
REQ-023 SHALL drive inst_valid = (head != fill || filled entries exist), i.e. head entry has data; inst_data/inst_pc = entry[head].
REQ-024 On inst_valid && inst_ready && !flush SHALL advance head and decrement count.
REQ-025 Response-to-inst_valid latency SHALL be exactly 1 cycle (data registered, no bypass).
REQ-026 Simultaneous issue, response and pop in one cycle SHALL all take effect; count changes by (+1 issue, -1 pop).
REQ-027 On flush SHALL set head = fill = tail, count = 0, and drop = (outstanding requests) - (1 if imem_resp_valid and drop == 0 that cycle else 0) + (existing drop - 1 if discarding that cycle); inst_valid SHALL be 0 the following cycle.
REQ-028 Outstanding requests SHALL be tracked as entries allocated but unfilled (tail - fill, distinguishing full/empty via count).
REQ-029 A response with no outstanding request and drop == 0 is a protocol violation and SHALL be ignored.
REQ-030 Pointer wrap SHALL be modulo DEPTH; counters SHALL be $clog2(DEPTH)+1 bits.

Reset
REQ-031 Reset SHALL set head, fill, tail, count, drop to 0; inst_valid, pc_ready, imem_req_valid SHALL be 0 in the reset cycle and inst_valid 0 the cycle after.
REQ-032 Reset SHALL take priority over flush, issue, response and pop; responses during reset are discarded.
REQ-033 Entry data/pc contents need not be reset.

Verification
REQ-034 Single fetch: pc_in=0x100, ready=1, response 2 cycles later with 0xDEADBEEF -> inst_valid next cycle with inst_pc=0x100, inst_data=0xDEADBEEF.
REQ-035 Full queue: DEPTH=4, inst_ready=0, 6 PCs 0x0..0x14 offered -> exactly 4 issued (0x0..0xC), pc_ready=0 thereafter; then 4 pops in order 0x0,0x4,0x8,0xC.
REQ-036 Flush in flight: 3 requests issued, no responses, flush -> next 3 responses dropped; new pc 0x200 issued after flush returns 0x200 as first inst_pc.
REQ-037 Simultaneous: full queue with head filled, inst_ready=1 and response same cycle -> count 4->3, no issue that cycle, issue resumes next cycle.
REQ-038 Reset mid-operation: 2 outstanding, reset 1 cycle -> inst_valid=0, subsequent responses ignored, first post-reset fetch 0x0 returns correctly.
REQ-039 Misaligned pc_in=0x103 -> imem_req_addr=0x100, inst_pc=0x103.
